// File: rtl/pkt_capture.sv
`default_nettype none
// ============================================================================
// Module   : pkt_capture
// Brief    : Avalon-ST packet capture into a FIFO with a length trailer and
//            ring-buffer address handoff to a downstream writer.
// Revision : 1.0
// ============================================================================
module pkt_capture #(
    parameter int MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] buf_base,
    input  logic [31:0] buf_size,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic [31:0] fifo_data,
    output logic        fifo_wrreq,
    input  logic        fifo_almost_full,
    output logic        wr_ctrl,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        TRAILER = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    localparam logic [31:0] C_PKT_BYTES = 32'(4 * MAX_WORDS);
    localparam logic [31:0] C_KEEP_MAX  = 32'(MAX_WORDS - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_start;
    logic        w_drop;
    logic        w_keep;
    logic        w_in_pkt;
    logic        w_done;
    logic [31:0] w_start_off;
    logic [31:0] w_kept_next;
    logic [15:0] w_len_eop;

    logic [31:0] r_wr_off;
    logic [31:0] r_kept;
    logic [15:0] r_len;
    logic        r_trunc;

    // Reset gates st_ready so the sink is closed for the whole reset window.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_drop       = 1'b0;
        w_keep       = 1'b0;
        w_done       = 1'b0;
        st_ready     = reset && ((r_state == IDLE) || (r_state == CAPTURE))
                       && !fifo_almost_full;
        w_accept     = st_valid && st_ready;
        case (r_state)
            IDLE: begin
                if (w_accept && st_sop) begin
                    if (enable) begin
                        w_start      = 1'b1;
                        w_keep       = 1'b1;
                        w_state_next = st_eop ? TRAILER : CAPTURE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (w_accept) begin
                    w_keep = (r_kept < C_KEEP_MAX);
                    if (st_eop) begin
                        w_state_next = TRAILER;
                    end
                end
            end
            TRAILER: begin
                w_state_next = HANDOFF;
            end
            HANDOFF: begin
                if (wr_ctrl && wr_ctrl_rdy) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A packet slot never straddles the ring end: restart at offset 0 instead.
    always_comb begin
        w_in_pkt    = w_start || ((r_state == CAPTURE) && w_accept);
        w_start_off = (({1'b0, r_wr_off} + {1'b0, C_PKT_BYTES}) > {1'b0, buf_size})
                      ? 32'd0 : r_wr_off;
        w_kept_next = (w_start ? 32'd0 : r_kept) + (w_keep ? 32'd1 : 32'd0);
        w_len_eop   = w_keep ? ({w_kept_next[13:0], 2'b00} - {14'd0, st_empty})
                             : {r_kept[13:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_wrreq <= 1'b0;
            fifo_data  <= 32'd0;
            wr_ctrl    <= 1'b0;
            pkt_begin  <= 32'd0;
            pkt_end    <= 32'd0;
            pkt_count  <= 32'd0;
            drop_count <= 32'd0;
            r_wr_off   <= 32'd0;
            r_kept     <= 32'd0;
            r_len      <= 16'd0;
            r_trunc    <= 1'b0;
        end else begin
            fifo_wrreq <= 1'b0;
            if (w_keep) begin
                fifo_wrreq <= 1'b1;
                fifo_data  <= st_data;
            end
            if (w_drop) begin
                drop_count <= drop_count + 32'd1;
            end
            if (w_start) begin
                r_wr_off  <= w_start_off;
                pkt_begin <= buf_base + w_start_off;
                r_trunc   <= 1'b0;
            end
            if (w_in_pkt) begin
                r_kept <= w_kept_next;
                if (st_eop) begin
                    r_len <= w_len_eop;
                end
            end
            if ((r_state == CAPTURE) && w_accept && !w_keep) begin
                r_trunc <= 1'b1;
            end
            if (r_state == TRAILER) begin
                fifo_wrreq <= 1'b1;
                fifo_data  <= {r_trunc, 15'd0, r_len};
                pkt_end    <= pkt_begin + {r_kept[29:0], 2'b00} + 32'd4;
            end
            // wr_ctrl rises one cycle after the trailer write, which happens
            // in the first HANDOFF cycle.
            if (w_done) begin
                wr_ctrl   <= 1'b0;
                r_wr_off  <= r_wr_off + {r_kept[29:0], 2'b00} + 32'd4;
                pkt_count <= pkt_count + 32'd1;
            end else if (r_state == HANDOFF) begin
                wr_ctrl <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_capture
// Brief    : Scoreboard bench for pkt_capture (default and MAX_WORDS=4 builds).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pkt_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        fifo_af;
    logic        wr_ctrl_rdy;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic [1:0]  st_empty;
    logic [31:0] st_data;
    logic        sel;

    logic [31:0] base_a = 32'h0000_1000;
    logic [31:0] size_a = 32'h0001_0000;
    logic [31:0] base_b = 32'h0000_2000;
    logic [31:0] size_b = 32'h0000_0020;

    logic        a_ready, a_wrreq, a_wrctrl;
    logic [31:0] a_fdata, a_begin, a_end, a_pcnt, a_dcnt;
    logic        b_ready, b_wrreq, b_wrctrl;
    logic [31:0] b_fdata, b_begin, b_end, b_pcnt, b_dcnt;

    logic        m_ready, m_wrreq, m_wrctrl;
    logic [31:0] m_fdata, m_begin, m_end, m_pcnt, m_dcnt;
    assign m_ready  = sel ? b_ready  : a_ready;
    assign m_wrreq  = sel ? b_wrreq  : a_wrreq;
    assign m_wrctrl = sel ? b_wrctrl : a_wrctrl;
    assign m_fdata  = sel ? b_fdata  : a_fdata;
    assign m_begin  = sel ? b_begin  : a_begin;
    assign m_end    = sel ? b_end    : a_end;
    assign m_pcnt   = sel ? b_pcnt   : a_pcnt;
    assign m_dcnt   = sel ? b_dcnt   : a_dcnt;

    pkt_capture #(.MAX_WORDS(512)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .buf_base(base_a), .buf_size(size_a),
        .st_data(st_data), .st_valid(st_valid & ~sel), .st_ready(a_ready),
        .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
        .fifo_data(a_fdata), .fifo_wrreq(a_wrreq), .fifo_almost_full(fifo_af),
        .wr_ctrl(a_wrctrl), .wr_ctrl_rdy(wr_ctrl_rdy & ~sel),
        .pkt_begin(a_begin), .pkt_end(a_end),
        .pkt_count(a_pcnt), .drop_count(a_dcnt)
    );

    pkt_capture #(.MAX_WORDS(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .buf_base(base_b), .buf_size(size_b),
        .st_data(st_data), .st_valid(st_valid & sel), .st_ready(b_ready),
        .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
        .fifo_data(b_fdata), .fifo_wrreq(b_wrreq), .fifo_almost_full(fifo_af),
        .wr_ctrl(b_wrctrl), .wr_ctrl_rdy(wr_ctrl_rdy & sel),
        .pkt_begin(b_begin), .pkt_end(b_end),
        .pkt_count(b_pcnt), .drop_count(b_dcnt)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int unsigned m_off[2];
    int unsigned m_cnt[2];

    // Scoreboard: every FIFO write of the selected build must match the queue head.
    always @(negedge clk) begin
        if (reset && m_wrreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_extra: got write 0x%08h, expected no write", m_fdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_fdata !== mon_exp) begin
                    errors++;
                    $display("FAIL fifo_data: got 0x%08h, expected 0x%08h", m_fdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop,
                             input logic [1:0] emp, input bit stall, output int waited);
        bit done;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_empty = emp;
        st_valid = 1'b1;
        waited   = 0;
        if (stall) begin
            fifo_af = 1'b1;
            repeat (2) begin
                @(negedge clk);
                checks++;
                if (m_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got %b, expected 0", m_ready);
                end
                @(posedge clk); #1;
            end
            fifo_af = 1'b0;
        end
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                done = 1'b1;
            end else if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: st_ready stuck at %b, expected 1", m_ready);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Drives one packet on the selected build; expectations come from the
    // packet format and ring rules, not from the DUT.
    task automatic run_pkt(input int n, input logic [31:0] d0, input logic [1:0] emp,
                           input int stall_at, input int rdy_delay, input bit finish);
        int unsigned maxw, kept, off, t, w;
        logic [31:0] base, size, len, tr, exp_begin, exp_end;
        bit trunc;
        maxw  = sel ? 4 : 512;
        base  = sel ? base_b : base_a;
        size  = sel ? size_b : size_a;
        kept  = (n < maxw - 1) ? n : maxw - 1;
        trunc = (n > maxw - 1);
        len   = trunc ? 4 * kept : 4 * n - emp;
        off   = (m_off[sel] + 4 * maxw > size) ? 0 : m_off[sel];
        exp_begin = base + off;
        exp_end   = exp_begin + 4 * (kept + 1);
        for (int i = 0; i < kept; i++) exp_q.push_back(d0 + 32'(i));
        tr = {trunc, 15'd0, len[15:0]};
        exp_q.push_back(tr);
        for (int i = 0; i < n; i++)
            send_beat(d0 + 32'(i), i == 0, i == n - 1, (i == n - 1) ? emp : 2'd0,
                      i == stall_at, w);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (m_wrctrl !== 1'b1 && t < 200);
        checks++;
        if (m_wrctrl !== 1'b1) begin
            errors++;
            $display("FAIL wr_ctrl_rise: got %b, expected 1", m_wrctrl);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_missing: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (m_begin !== exp_begin) begin
            errors++;
            $display("FAIL pkt_begin: got 0x%08h, expected 0x%08h", m_begin, exp_begin);
        end
        checks++;
        if (m_end !== exp_end) begin
            errors++;
            $display("FAIL pkt_end: got 0x%08h, expected 0x%08h", m_end, exp_end);
        end
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL handoff_ready: got %b, expected 0", m_ready);
        end
        if (!finish) return;
        @(posedge clk); #1;
        repeat (rdy_delay) begin
            @(posedge clk); #1;
        end
        checks++;
        if (m_wrctrl !== 1'b1) begin
            errors++;
            $display("FAIL wr_ctrl_hold: got %b, expected 1", m_wrctrl);
        end
        wr_ctrl_rdy = 1'b1;
        @(posedge clk); #1;
        wr_ctrl_rdy = 1'b0;
        m_off[sel] = off + 4 * (kept + 1);
        m_cnt[sel] = m_cnt[sel] + 1;
        @(negedge clk);
        checks++;
        if (m_wrctrl !== 1'b0) begin
            errors++;
            $display("FAIL wr_ctrl_fall: got %b, expected 0", m_wrctrl);
        end
        checks++;
        if (m_pcnt !== m_cnt[sel]) begin
            errors++;
            $display("FAIL pkt_count: got %0d, expected %0d", m_pcnt, m_cnt[sel]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, expected 0", a_ready); end
        checks++;
        if (a_wrreq !== 1'b0) begin errors++; $display("FAIL rst_wrreq: got %b, expected 0", a_wrreq); end
        checks++;
        if (a_fdata !== 32'd0) begin errors++; $display("FAIL rst_fdata: got 0x%08h, expected 0", a_fdata); end
        checks++;
        if (a_wrctrl !== 1'b0) begin errors++; $display("FAIL rst_wrctrl: got %b, expected 0", a_wrctrl); end
        checks++;
        if (a_begin !== 32'd0 || a_end !== 32'd0) begin
            errors++;
            $display("FAIL rst_addr: got 0x%08h/0x%08h, expected 0/0", a_begin, a_end);
        end
        checks++;
        if (a_pcnt !== 32'd0 || a_dcnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_counts: got %0d/%0d, expected 0/0", a_pcnt, a_dcnt);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", a_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_pkt(8, 32'd10, 2'd0, -1, 3, 1'b1);
    endtask

    task automatic test_odd_length();
        run_pkt(3, 32'h100, 2'd3, -1, 0, 1'b1);
        run_pkt(1, 32'h200, 2'd1, -1, 1, 1'b1);
    endtask

    task automatic test_stall();
        run_pkt(8, 32'h300, 2'd0, 3, 1, 1'b1);
    endtask

    task automatic test_truncate_wrap();
        sel = 1'b1;
        run_pkt(6, 32'h400, 2'd2, -1, 0, 1'b1);
        run_pkt(6, 32'h410, 2'd0, -1, 0, 1'b1);
        run_pkt(2, 32'h420, 2'd0, -1, 2, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_disabled_drop();
        int w;
        logic [31:0] dcnt0, pcnt0;
        dcnt0  = a_dcnt;
        pcnt0  = a_pcnt;
        enable = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                send_beat(32'h700 + 32'(i), i == 0, i == 2, 2'd0, 1'b0, w);
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL drop_ready: waited %0d cycles, expected 0", w);
                end
            end
        end
        st_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_dcnt !== dcnt0 + 32'd2) begin
            errors++;
            $display("FAIL drop_count: got %0d, expected %0d", a_dcnt, dcnt0 + 32'd2);
        end
        checks++;
        if (a_pcnt !== pcnt0) begin
            errors++;
            $display("FAIL drop_pkt_count: got %0d, expected %0d", a_pcnt, pcnt0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic test_reset_in_handoff();
        run_pkt(2, 32'h500, 2'd0, -1, 0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_off[0] = 0;
        m_cnt[0] = 0;
        @(negedge clk);
        checks++;
        if (a_wrctrl !== 1'b0) begin errors++; $display("FAIL rih_wrctrl: got %b, expected 0", a_wrctrl); end
        checks++;
        if (a_pcnt !== 32'd0 || a_dcnt !== 32'd0) begin
            errors++;
            $display("FAIL rih_counts: got %0d/%0d, expected 0/0", a_pcnt, a_dcnt);
        end
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL rih_ready: got %b, expected 1", a_ready); end
        @(posedge clk); #1;
        run_pkt(2, 32'h600, 2'd0, -1, 1, 1'b1);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        fifo_af     = 1'b0;
        wr_ctrl_rdy = 1'b0;
        st_valid    = 1'b0;
        st_sop      = 1'b0;
        st_eop      = 1'b0;
        st_empty    = 2'd0;
        st_data     = 32'd0;
        sel         = 1'b0;
        m_off[0] = 0; m_off[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_odd_length();
        test_stall();
        test_truncate_wrap();
        test_disabled_drop();
        test_reset_in_handoff();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_capture.md
PKT_CAPTURE -- requirements
Module: pkt_capture

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 512, meaning the maximum FIFO words per packet including the trailer.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL have port enable, input, 1, capture enable.
REQ-005 SHALL have ports buf_base and buf_size, input, 32 each: ring buffer base byte address and size in bytes (multiple of 4, at least 4*MAX_WORDS).
REQ-006 SHALL have Avalon-ST sink ports st_data (in 32), st_valid (in 1), st_ready (out 1), st_sop (in 1), st_eop (in 1), st_empty (in 2, invalid bytes on the eop beat).
REQ-007 SHALL have FIFO write ports fifo_data (out 32), fifo_wrreq (out 1) and fifo_almost_full (in 1).
REQ-008 SHALL have writer handoff ports wr_ctrl (out 1), wr_ctrl_rdy (in 1), pkt_begin (out 32) and pkt_end (out 32), all byte addresses.
REQ-009 SHALL have ports pkt_count and drop_count, output, 32 each: statistics counters.

Function
REQ-010 SHALL implement four states: IDLE, CAPTURE, TRAILER and HANDOFF.
REQ-011 SHALL drive st_ready = (state is IDLE or CAPTURE) and !fifo_almost_full; a beat is accepted when st_valid & st_ready.
REQ-012 In IDLE, an accepted beat with st_sop=1 and enable=1 SHALL start a packet (go to CAPTURE).
REQ-013 In IDLE, an accepted beat with sop=1 and enable=0 SHALL be discarded and SHALL increment drop_count; non-sop beats in IDLE SHALL be discarded silently.
REQ-014 SHALL write each kept data beat to the FIFO registered: the beat accepted at edge N drives fifo_wrreq=1 and fifo_data=st_data in the cycle after edge N.
REQ-015 A packet with sop=1 and eop=1 on the same beat SHALL be a valid 1-word packet.
REQ-016 A sop beat seen in CAPTURE SHALL be treated as data; there is no restart.
REQ-017 SHALL keep at most MAX_WORDS-1 data words; later beats up to eop SHALL be accepted but not written, and the packet SHALL be marked truncated.
REQ-018 byte_len SHALL be 4*kept_words minus st_empty if the eop beat was kept; if the eop beat was not kept, byte_len SHALL be 4*kept_words.
REQ-019 On eop SHALL go to TRAILER, which writes one word {truncated, 15'b0, byte_len[15:0]} in the cycle after the last data write; this is exactly one cycle, and st_ready=0 during it.
REQ-020 pkt_begin SHALL equal buf_base + wr_off latched at sop, and pkt_end SHALL equal pkt_begin + 4*(kept_words+1).
REQ-021 On entering HANDOFF, SHALL drive wr_ctrl=1 from the cycle after the trailer write, holding pkt_begin and pkt_end stable.
REQ-022 SHALL hold wr_ctrl high until wr_ctrl_rdy is sampled 1 in HANDOFF, then drop wr_ctrl and return to IDLE; wr_ctrl_rdy outside HANDOFF SHALL be ignored.
REQ-023 In HANDOFF, st_ready SHALL be 0 (backpressure); the FIFO SHALL never hold more than one packet.
REQ-024 On return to IDLE, SHALL set wr_off += 4*(kept_words+1) and increment pkt_count.
REQ-025 Ring wrap: at sop, if wr_off + 4*MAX_WORDS > buf_size, SHALL reset wr_off to 0 before latching pkt_begin; packets never straddle the ring end.
REQ-026 Counters and wr_off SHALL wrap modulo 2^32 without saturation.
REQ-027 enable falling mid-packet SHALL NOT abort the packet; it affects only the next sop.
REQ-028 fifo_almost_full rising mid-packet SHALL only stall st_ready; no beat is lost or duplicated.

Reset
REQ-029 While reset=0 at a clock edge, the block SHALL go to IDLE and set st_ready=0, fifo_wrreq=0, fifo_data=0, wr_ctrl=0, pkt_begin=0, pkt_end=0, pkt_count=0, drop_count=0 and wr_off=0.
REQ-030 Reset mid-packet or in HANDOFF SHALL abandon the packet with no trailer and no count; the first cycle after reset SHALL allow st_ready=1.

Verification
REQ-031 Scenario (basic): buf_base=0x1000, 8 beats 10..17 with sop on beat 10, eop on beat 17, empty=0, wr_ctrl_rdy=1 after 3 cycles -> FIFO gets 10..17 then 0x00000020; wr_ctrl=1 with pkt_begin=0x1000 and pkt_end=0x1024; pkt_count=1; next pkt_begin=0x1024.
REQ-032 Scenario (odd length): 3-beat packet with empty=3 -> trailer 0x00000009.
REQ-033 Scenario (stall): fifo_almost_full pulsed 2 cycles mid-packet -> st_ready=0 for those cycles; FIFO content matches with no gaps or duplicates.
REQ-034 Scenario (truncate and wrap): MAX_WORDS=4, buf_size=0x20, 6-beat packet -> 3 data words, trailer 0x8000000C, pkt_end=pkt_begin+16; the second packet starts at buf_base+0x10; the third packet wraps to buf_base.
REQ-035 Scenario (disabled drop): enable=0, two packets -> no FIFO writes, drop_count=2, st_ready=1 throughout.
REQ-036 Scenario (reset in HANDOFF): reset=0 for 1 cycle -> wr_ctrl=0, counters=0, pkt_begin=buf_base on the next packet.
